// File: rtl/dht11_pkg.sv
// dht11_pkg
//   Shared definitions for the DHT11 report path: FSM state encoding,
//   status byte bit positions, the default packet header and the packet
//   lengths for the integer-only and fractional report formats.
package dht11_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_SEND  = 2'd2
    } state_e;

    localparam int STAT_CKS_BIT    = 0;
    localparam int STAT_SENSOR_BIT = 1;
    localparam int STAT_OVR_BIT    = 7;

    localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

    localparam int PKT_LEN_BASE = 4;
    localparam int PKT_LEN_FRAC = 6;

    // 8-bit wrapping sum of the four payload bytes of a frame.
    function automatic logic [7:0] frame_sum(input logic [39:0] f);
        return f[39:32] + f[31:24] + f[23:16] + f[15:8];
    endfunction

endpackage

// File: rtl/dht11_uart_report_uart_tx_byte.sv
// uart_tx_byte
//   10-cycle 8N1 byte shifter, one bit per clock.
//   Ports:
//     clk_115200hz  bit clock
//     reset         asynchronous, active-high; line returns to idle high
//     load          start a byte on this edge (start bit driven from it)
//     data          byte to send, LSB first
//     done          line is free after this cycle (idle, or stop bit on line);
//                   a load issued while done is high gives back-to-back bytes
//     tx            serial output, idle high
module uart_tx_byte (
    input  logic       clk_115200hz,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] data,
    output logic       done,
    output logic       tx
);

    // cnt_q is the bit on the line: 0 start, 1..8 data, 9 stop
    logic       active_q, active_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] shreg_q, shreg_d;
    logic       tx_q, tx_d;

    always_comb begin
        active_d = active_q;
        cnt_d    = cnt_q;
        shreg_d  = shreg_q;
        tx_d     = tx_q;
        if (load) begin
            active_d = 1'b1;
            cnt_d    = 4'd0;
            shreg_d  = data;
            tx_d     = 1'b0;
        end else if (active_q) begin
            if (cnt_q == 4'd9) begin
                active_d = 1'b0;
                tx_d     = 1'b1;
            end else begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q < 4'd8) begin
                    tx_d    = shreg_q[0];
                    shreg_d = {1'b0, shreg_q[7:1]};
                end else begin
                    tx_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_115200hz or posedge reset) begin
        if (reset) begin
            active_q <= 1'b0;
            cnt_q    <= 4'd0;
            tx_q     <= 1'b1;
        end else begin
            active_q <= active_d;
            cnt_q    <= cnt_d;
            tx_q     <= tx_d;
        end
    end

    always_ff @(posedge clk_115200hz) begin
        shreg_q <= shreg_d;
    end

    assign done = !active_q || (cnt_q == 4'd9);
    assign tx   = tx_q;

endmodule

// File: rtl/dht11_uart_report.sv
// dht11_uart_report
//   Accepts one 40-bit DHT11 frame per handshake, verifies its checksum and
//   sends a report packet (HEADER, status, humidity, temperature) as 8N1
//   UART at one bit per clock.
//   Build option: define DHT11_FRAC_EN to send the 6-byte packet that also
//   carries the fractional humidity/temperature bytes.
//   Ports:
//     clk_115200hz  bit clock
//     reset         asynchronous, active-high
//     frame_valid   frame offered this cycle
//     frame         {hum_int, hum_frac, temp_int, temp_frac, checksum}
//     sensor_err    receiver error for the offered frame
//     frame_ready   idle, frame accepted when frame_valid && frame_ready
//     busy          packet in progress (!frame_ready)
//     checksum_err  checksum result of the last accepted frame
//     uart_tx       serial line, idle high
module dht11_uart_report
    import dht11_pkg::*;
#(
    parameter logic [7:0] HEADER = HEADER_DEFAULT
) (
    input  logic        clk_115200hz,
    input  logic        reset,
    input  logic        frame_valid,
    input  logic [39:0] frame,
    input  logic        sensor_err,
    output logic        frame_ready,
    output logic        busy,
    output logic        checksum_err,
    output logic        uart_tx
);

`ifdef DHT11_FRAC_EN
    localparam int PKT_LEN = PKT_LEN_FRAC;
`else
    localparam int PKT_LEN = PKT_LEN_BASE;
`endif
    localparam logic [2:0] LAST_IDX = 3'(PKT_LEN);

    state_e      state_q, state_d;
    logic [39:0] frame_q, frame_d;
    logic        sensor_err_q, sensor_err_d;
    logic [7:0]  status_q, status_d;
    logic        checksum_err_q, checksum_err_d;
    logic        overrun_q, overrun_d;
    logic [2:0]  byte_idx_q, byte_idx_d;

    logic        tx_load;
    logic        tx_done;
    logic [7:0]  tx_byte;
    logic        cks_bad;
    logic [7:0]  hum_int, hum_frac, temp_int, temp_frac;

    assign cks_bad = (frame_sum(frame_q) != frame_q[7:0]);

    // A sensor error blanks every measurement byte.
    assign hum_int   = sensor_err_q ? 8'h00 : frame_q[39:32];
    assign hum_frac  = sensor_err_q ? 8'h00 : frame_q[31:24];
    assign temp_int  = sensor_err_q ? 8'h00 : frame_q[23:16];
    assign temp_frac = sensor_err_q ? 8'h00 : frame_q[15:8];

    always_comb begin
        tx_byte = 8'hFF;
        case (byte_idx_q)
            3'd0: tx_byte = HEADER;
            3'd1: tx_byte = status_q;
`ifdef DHT11_FRAC_EN
            3'd2: tx_byte = hum_int;
            3'd3: tx_byte = hum_frac;
            3'd4: tx_byte = temp_int;
            3'd5: tx_byte = temp_frac;
`else
            3'd2: tx_byte = hum_int;
            3'd3: tx_byte = temp_int;
`endif
            default: tx_byte = 8'hFF;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        frame_d        = frame_q;
        sensor_err_d   = sensor_err_q;
        status_d       = status_q;
        checksum_err_d = checksum_err_q;
        overrun_d      = overrun_q;
        byte_idx_d     = byte_idx_q;
        tx_load        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (frame_valid) begin
                    frame_d      = frame;
                    sensor_err_d = sensor_err;
                    state_d      = ST_CHECK;
                end
            end
            ST_CHECK: begin
                checksum_err_d                = cks_bad;
                status_d                      = 8'h00;
                status_d[STAT_CKS_BIT]        = cks_bad && !sensor_err_q;
                status_d[STAT_SENSOR_BIT]     = sensor_err_q;
                status_d[STAT_OVR_BIT]        = overrun_q;
                overrun_d                     = 1'b0;
                byte_idx_d                    = 3'd0;
                state_d                       = ST_SEND;
            end
            ST_SEND: begin
                // byte_idx_q counts bytes already handed to the shifter
                if (tx_done) begin
                    if (byte_idx_q == LAST_IDX) begin
                        state_d = ST_IDLE;
                    end else begin
                        tx_load    = 1'b1;
                        byte_idx_d = byte_idx_q + 3'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A drop on the CHECK edge belongs to the next packet, so set wins.
        if (frame_valid && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk_115200hz or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            checksum_err_q <= 1'b0;
            overrun_q      <= 1'b0;
            byte_idx_q     <= 3'd0;
        end else begin
            state_q        <= state_d;
            checksum_err_q <= checksum_err_d;
            overrun_q      <= overrun_d;
            byte_idx_q     <= byte_idx_d;
        end
    end

    always_ff @(posedge clk_115200hz) begin
        frame_q      <= frame_d;
        sensor_err_q <= sensor_err_d;
        status_q     <= status_d;
    end

    uart_tx_byte u_tx (
        .clk_115200hz (clk_115200hz),
        .reset        (reset),
        .load         (tx_load),
        .data         (tx_byte),
        .done         (tx_done),
        .tx           (uart_tx)
    );

    assign frame_ready  = (state_q == ST_IDLE);
    assign busy         = !frame_ready;
    assign checksum_err = checksum_err_q;

endmodule

// File: doc/dht11_uart_report.md
# dht11_uart_report

Downstream stage of the DHT11 receiver. Accepts one 40-bit sensor frame per handshake, verifies the checksum, and transmits a fixed-format report packet as 8N1 UART on `uart_tx` at one bit per `clk_115200hz` cycle (115200 baud). Sits between the DHT11 receive FSM and the board TX pin.

## Interface
- `HEADER`, default 8'hA5: first byte of every packet.
- `clk_115200hz`  in  1  bit clock; one UART bit per cycle.
- `reset`  in  1  asynchronous, active-high; clock `clk_115200hz`.
- `frame_valid`  in  1  frame offered this cycle.
- `frame`  in  40  {hum_int, hum_frac, temp_int, temp_frac, checksum}, MSB byte first.
- `sensor_err`  in  1  receiver timeout/protocol error for this frame; sampled with `frame_valid`.
- `frame_ready`  out  1  high when idle; frame accepted on an edge where `frame_valid && frame_ready`.
- `busy`  out  1  packet in progress (equal to `!frame_ready`).
- `checksum_err`  out  1  registered result of the last accepted frame; held until the next accept.
- `uart_tx`  out  1  serial line, idle high.

## Operation
- Reset values: `uart_tx`=1, `frame_ready`=1, `busy`=0, `checksum_err`=0, overrun flag=0, FSM=IDLE.
- FSM states: IDLE, CHECK, SEND, then back to IDLE.
  - IDLE: on accept, latch `frame` and `sensor_err`, go to CHECK.
  - CHECK: compute sum = (b4+b3+b2+b1) mod 256 (8-bit wrap); `checksum_err` = (sum != b0). Build status byte, go to SEND, byte index = 0.
  - SEND: shift out bytes in order; after the stop bit of the last byte, go to IDLE.
- Status byte: bit0 = checksum_err, bit1 = sensor_err, bit7 = overrun, other bits 0.
- Packet (4 bytes): HEADER, status, hum_int, temp_int.
- When `sensor_err`=1, data bytes are sent as 8'h00 and bit0 is forced to 0 (sensor error has priority). On checksum error alone, raw data bytes are sent.
- Each byte: start 0, 8 data bits LSB first, stop 1, giving 10 cycles with no idle gap between bytes.
- `frame_valid` while busy: frame dropped and the overrun flag set. The flag is reported in bit7 of the next packet's status byte and cleared at that packet's CHECK. Accept and overrun on the same edge cannot occur.
- Reset mid-packet: `uart_tx` goes to 1 immediately (asynchronous) and the packet is abandoned. No resume.

## Timing
- Accept at edge N. CHECK completes at edge N+1. Start bit of HEADER is driven from edge N+2.
- Byte k start bit at edge N+2+10k. Bit j (0..7) at N+3+10k+j. Stop bit at N+11+10k.
- With B bytes, `frame_ready` returns high at edge N+2+10B (N+42 for 4 bytes). A new frame may be accepted on that edge.
- `checksum_err` updates at edge N+1.
- `busy` is high from edge N to edge N+2+10B.

## Configuration
- `DHT11_FRAC_EN` defined: packet is 6 bytes (HEADER, status, hum_int, hum_frac, temp_int, temp_frac). Cycle count is 62; `frame_ready` returns at N+62.
- Not defined: 4-byte packet as above. Fractional bytes still enter the checksum but are never transmitted.

## Structure
- Shared package `dht11_pkg`: FSM state enum, status bit positions, default header constant, packet length constants (4/6).
- One sub-module, `uart_tx_byte`. It has load/byte inputs and `done`/`tx` outputs and implements the 10-cycle 8N1 shifter with a bit counter. The top holds the FSM, checksum, and byte index.

## Test plan
- Frame 40'h35_00_18_00_4D, `sensor_err`=0: decoded bytes A5 00 35 18. `checksum_err`=0. `frame_ready` high at N+42.
- Frame 40'h35_00_18_00_4E: bytes A5 01 35 18. `checksum_err`=1 from edge N+1.
- Any frame with `sensor_err`=1: bytes A5 02 00 00.
- Second `frame_valid` pulse at N+20: no accept, first packet unchanged. Next accepted frame 40'h35_00_18_00_4D yields status 8'h80.
- Assert `reset` at N+15: `uart_tx`=1 within the same cycle, `frame_ready`=1, and the next packet starts clean.
- With `DHT11_FRAC_EN`, frame 40'h35_05_18_03_55: bytes A5 00 35 05 18 03. `frame_ready` high at N+62. Checksum wrap case 40'hFF_FF_01_01_00 gives `checksum_err`=0.
